// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM state
// encoding, grant identity and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_DATA  = 1'b0,
    GNT_FETCH = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port memory between the instruction-fetch
// and data ports; round-robin on ties, one access in flight at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall
);

  state_t            state;
  state_t            state_nxt;
  grant_t            last_grant;
  grant_t            grant_nxt;
  logic              take;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic              busy;

  assign busy = (state == DATA) || (state == FETCH);

  always_comb begin
    state_nxt = state;
    grant_nxt = last_grant;
    take      = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time gets the memory.
        if (d_req && if_req) begin
          take      = 1'b1;
          grant_nxt = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (d_req) begin
          take      = 1'b1;
          grant_nxt = GNT_DATA;
        end else if (if_req) begin
          take      = 1'b1;
          grant_nxt = GNT_FETCH;
        end
        if (take) begin
          state_nxt = (grant_nxt == GNT_DATA) ? DATA : FETCH;
        end
      end
      DATA, FETCH: begin
        if (mem_ready) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // last_grant doubles as the identity of the access currently in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= GNT_FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (take) begin
        last_grant <= grant_nxt;
        if (grant_nxt == GNT_DATA) begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_we;
        end else begin
          addr_q  <= if_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      end
      if (busy && mem_ready) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_en    = busy;
  assign mem_we    = (state == DATA) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign d_ack     = (state == RESP) && (last_grant == GNT_DATA);
  assign if_ack    = (state == RESP) && (last_grant == GNT_FETCH);
  assign d_rdata   = rdata_q;
  assign if_rdata  = rdata_q;

  assign stall     = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed latency/tie/wait/reset cases, then
// random two-port traffic against a request scoreboard and memory model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  req_t d_q[$];
  req_t if_q[$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a * 32'd3) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t          de;
    req_t          ie;
    int            issued;
    int            cycles;
    int            d_wait;
    int            if_wait;
    logic          d_pend;
    logic          if_pend;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          cap_we;

    idle_inputs();
    reset_n = 1'b0;
    #12;
    check_val("rst_if_ack", 64'(if_ack), 64'd0);
    check_val("rst_d_ack",  64'(d_ack),  64'd0);
    check_val("rst_mem_en", 64'(mem_en), 64'd0);
    check_val("rst_mem_we", 64'(mem_we), 64'd0);
    check_val("rst_addr",   64'(mem_addr), 64'd0);
    check_val("rst_rdata",  64'(d_rdata), 64'd0);
    check_val("rst_stall",  64'(stall), 64'd0);
    reset_n = 1'b1;
    step();

    // Minimum-latency load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check_val("ld_stall_c0", 64'(stall), 64'd1);
    step();
    check_val("ld_en_c1",   64'(mem_en), 64'd1);
    check_val("ld_addr_c1", 64'(mem_addr), 64'h40);
    check_val("ld_we_c1",   64'(mem_we), 64'd0);
    check_val("ld_ack_c1",  64'(d_ack), 64'd0);
    step();
    check_val("ld_ack_c2",   64'(d_ack), 64'd1);
    check_val("ld_rdata_c2", 64'(d_rdata), 64'hDEAD_BEEF);
    check_val("ld_ifack_c2", 64'(if_ack), 64'd0);
    check_val("ld_en_c2",    64'(mem_en), 64'd0);
    d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Ties alternate, data first after reset
    do_reset();
    mem_ready = 1'b1; mem_rdata = 32'h1111_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h200;
    step();
    check_val("tie1_addr", 64'(mem_addr), 64'h100);
    step();
    check_val("tie1_dack",  64'(d_ack), 64'd1);
    check_val("tie1_ifack", 64'(if_ack), 64'd0);
    d_addr = 32'h104;
    step();
    check_val("tie_idle_en", 64'(mem_en), 64'd0);
    step();
    check_val("tie2_addr", 64'(mem_addr), 64'h200);
    check_val("tie2_we",   64'(mem_we), 64'd0);
    step();
    check_val("tie2_ifack", 64'(if_ack), 64'd1);
    check_val("tie2_dack",  64'(d_ack), 64'd0);
    if_addr = 32'h204;
    step();
    step();
    check_val("tie3_addr", 64'(mem_addr), 64'h104);
    step();
    check_val("tie3_dack", 64'(d_ack), 64'd1);
    d_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
    step();

    // Store with three wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
    mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_val("st_en",    64'(mem_en), 64'd1);
      check_val("st_we",    64'(mem_we), 64'd1);
      check_val("st_addr",  64'(mem_addr), 64'h80);
      check_val("st_wdata", 64'(mem_wdata), 64'h1234_5678);
      check_val("st_noack", 64'(d_ack), 64'd0);
      if (i == 4) mem_ready = 1'b1;
    end
    step();
    check_val("st_ack", 64'(d_ack), 64'd1);
    check_val("st_en_off", 64'(mem_en), 64'd0);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    step();

    // Fetch at address zero
    if_req = 1'b1; if_addr = 32'h0; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check_val("f_stall_c0", 64'(stall), 64'd1);
    step();
    check_val("f_stall_c1", 64'(stall), 64'd1);
    check_val("f_en_c1",    64'(mem_en), 64'd1);
    check_val("f_we_c1",    64'(mem_we), 64'd0);
    check_val("f_addr_c1",  64'(mem_addr), 64'h0);
    step();
    check_val("f_ack_c2",   64'(if_ack), 64'd1);
    check_val("f_rdata_c2", 64'(if_rdata), 64'hCAFE_F00D);
    check_val("f_stall_c2", 64'(stall), 64'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    // Reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_ready = 1'b0;
    step();
    check_val("ra_en_pre", 64'(mem_en), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("ra_en_async", 64'(mem_en), 64'd0);
    check_val("ra_noack",    64'(d_ack), 64'd0);
    check_val("ra_addr_clr", 64'(mem_addr), 64'd0);
    check_val("ra_stall",    64'(stall), 64'd1);
    #2;
    reset_n = 1'b1;
    d_addr = 32'h48; mem_ready = 1'b1; mem_rdata = 32'h0BAD_C0DE;
    step();
    check_val("ra_noack2", 64'(d_ack), 64'd0);
    check_val("ra_en2",    64'(mem_en), 64'd1);
    check_val("ra_addr2",  64'(mem_addr), 64'h48);
    step();
    check_val("ra_ack",   64'(d_ack), 64'd1);
    check_val("ra_rdata", 64'(d_rdata), 64'h0BAD_C0DE);
    d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Random concurrent traffic against the scoreboard
    do_reset();
    issued = 0; cycles = 0; d_wait = 0; if_wait = 0;
    d_pend = 1'b0; if_pend = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
    while ((issued < 1000 || d_pend || if_pend) && cycles < 20000) begin
      check_val("ack_excl", 64'(if_ack & d_ack), 64'd0);
      if (d_ack) begin
        if (d_q.size() == 0) begin
          check_val("d_ack_spurious", 64'd1, 64'd0);
        end else begin
          de = d_q.pop_front();
          check_val("d_addr", 64'(cap_addr), 64'(de.addr));
          check_val("d_we",   64'(cap_we), 64'(de.we));
          if (de.we) check_val("d_wdata", 64'(cap_wdata), 64'(de.wdata));
          else       check_val("d_rdata", 64'(d_rdata), 64'(mem_fn(de.addr)));
          check_val("d_wait", 64'(d_wait <= 2), 64'd1);
        end
        d_pend = 1'b0;
        if (if_pend) if_wait++;
      end
      if (if_ack) begin
        if (if_q.size() == 0) begin
          check_val("if_ack_spurious", 64'd1, 64'd0);
        end else begin
          ie = if_q.pop_front();
          check_val("if_addr",  64'(cap_addr), 64'(ie.addr));
          check_val("if_we",    64'(cap_we), 64'd0);
          check_val("if_rdata", 64'(if_rdata), 64'(mem_fn(ie.addr)));
          check_val("if_wait",  64'(if_wait <= 2), 64'd1);
        end
        if_pend = 1'b0;
        if (d_pend) d_wait++;
      end

      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = mem_fn(mem_addr);
      if (mem_en && mem_ready) begin
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end

      if (!d_pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
        de.addr  = $urandom & ~32'h3;
        de.we    = 1'($urandom_range(0, 1));
        de.wdata = $urandom;
        d_q.push_back(de);
        d_req = 1'b1; d_we = de.we; d_addr = de.addr; d_wdata = de.wdata;
        d_pend = 1'b1; d_wait = 0; issued++;
      end else if (!d_pend) begin
        d_req = 1'b0;
      end
      if (!if_pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
        ie.addr  = $urandom & ~32'h3;
        ie.we    = 1'b0;
        ie.wdata = '0;
        if_q.push_back(ie);
        if_req = 1'b1; if_addr = ie.addr;
        if_pend = 1'b1; if_wait = 0; issued++;
      end else if (!if_pend) begin
        if_req = 1'b0;
      end

      step();
      cycles++;
    end
    check_val("rand_drain", 64'(cycles < 20000), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
